binary_counter3_checker: RTL and testbench
==========================================

# binary_counter3_checker

Sequence checker for the binary counter family. It samples the counter's output and enable on each clock and verifies that the count holds when disabled and increments modulo 2^WIDTH when enabled. It reports lock status, single-cycle error and wrap pulses, and a saturating error count. It sits alongside the counter in designs and benches as the reader of the count it produces.

## Interface
- WIDTH, 3, counter width in bits
- LOCK_COUNT, 2, consecutive correct enabled increments required to lock (≥1)
- ERR_CNT_W, 8, width of the error counter
- CLOCK  in  1  rising-edge clock, shared with the counter
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  the same enable that drives the counter
- CNT_IN  in  WIDTH  counter output under check
- LOCKED  out  1  high while in the LOCKED state
- ERROR  out  1  one-cycle pulse on a mismatch while locked
- WRAP  out  1  one-cycle pulse on a correct (2^WIDTH−1)→0 transition
- ERR_COUNT  out  ERR_CNT_W  number of errors, saturating at all-ones
- LAST_BAD  out  WIDTH  CNT_IN value captured at the most recent error

## Operation
- One clock domain, CLOCK; reset is synchronous and active-high on RESET. All outputs are registered.
- History registers, loaded every non-reset edge:
  - prev_cnt ← CNT_IN
  - prev_en ← ENABLE
- Expected value: exp = prev_en ? (prev_cnt+1) mod 2^WIDTH : prev_cnt.
- Match: CNT_IN == exp.
- RESET=1 at an edge sets:
  - state = IDLE, good_cnt = 0
  - LOCKED = ERROR = WRAP = 0, ERR_COUNT = 0, LAST_BAD = 0
  - This holds regardless of state, so a mid-operation reset discards all history.
- IDLE: capture history only, no comparison. Go to SYNC.
- SYNC:
  - Match with prev_en=1: good_cnt+1. When the result reaches LOCK_COUNT, go to LOCKED and clear good_cnt.
  - Match with prev_en=0: good_cnt unchanged.
  - Mismatch: good_cnt = 0, stay in SYNC. No ERROR, ERR_COUNT unchanged.
- LOCKED:
  - Match: stay.
  - Mismatch: ERROR=1 for one cycle, ERR_COUNT+1 (holds at 2^ERR_CNT_W−1), LAST_BAD ← CNT_IN, go to SYNC, good_cnt = 0.
- WRAP: set for one cycle in SYNC or LOCKED when prev_en=1, prev_cnt = 2^WIDTH−1 and CNT_IN = 0. WRAP and ERROR are never asserted together.
- Illegal state encodings recover to IDLE.

## Timing
- Comparison uses the CNT_IN and ENABLE values present at edge k against history captured at edge k−1.
- ERROR, WRAP, ERR_COUNT and LAST_BAD update at edge k and are visible from edge k until edge k+1. Latency from a bad sample to the pulse is one edge.
- Lock latency with ENABLE continuously high from reset release:
  - First edge: IDLE capture.
  - Edges 2 through LOCK_COUNT+1: good increments.
  - LOCKED rises at edge LOCK_COUNT+1 (edge 3 for the default).
- LOCKED falls at the same edge that raises ERROR.
- A single disabled cycle in SYNC neither advances nor breaks lock acquisition.

## Structure
- Shared package/header `binary_counter3_pkg`:
  - State encodings IDLE, SYNC, LOCKED as 2-bit localparams.
  - Default WIDTH.
  - Shared with the counter and its benches.
- Natural sub-module `sat_counter` (parameter W; inputs inc, clr; output cnt, saturating), used for ERR_COUNT.
- Expected-value logic and the FSM stay inline.

## Test plan
- Reset, then ENABLE=0 with CNT_IN=0 for 6 cycles → LOCKED=0, ERROR=0, ERR_COUNT=0 throughout.
- ENABLE=1, CNT_IN 0,1,2,… → LOCKED rises when 2 is sampled. Continue 6,7,0 → WRAP high for exactly the cycle after 0 is sampled; ERROR stays 0.
- Locked at 3, drive 5 instead of 4 → ERROR one cycle, ERR_COUNT=1, LAST_BAD=5, LOCKED=0. Then 6,7 → LOCKED=1 again.
- Locked at 4, ENABLE=0, CNT_IN changes to 5 → ERROR pulse, ERR_COUNT+1 (a change while disabled counts as an error).
- ERR_CNT_W=2: force 5 errors, relocking between each → ERR_COUNT sequence 1,2,3,3,3.
- RESET high for one edge while LOCKED with ERR_COUNT=2 → all outputs 0 after that edge. The next edge is IDLE capture; no ERROR even if CNT_IN jumps.

Source files
------------

// File: rtl/binary_counter3_pkg.sv
// Shared definitions for the binary counter family and its sequence checker.
// State encodings are fixed 2-bit values so counters, checkers and benches agree.
package binary_counter3_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SYNC   = ST_SYNC,
        S_LOCKED = ST_LOCKED
    } chk_state_t;

endpackage

// File: rtl/binary_counter3_checker_sat_counter.sv
// Saturating up-counter: synchronous clear wins over increment, holds at all-ones.
// Latency: count visible one edge after inc; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/binary_counter3_checker.sv
// Sequence checker for a binary counter: verifies hold/increment behaviour against history.
// Latency: one edge from bad sample to ERROR; never stalls the counter it observes.
module binary_counter3_checker
    import binary_counter3_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [WIDTH-1:0]     CNT_IN,
    output logic                 LOCKED,
    output logic                 ERROR,
    output logic                 WRAP,
    output logic [ERR_CNT_W-1:0] ERR_COUNT,
    output logic [WIDTH-1:0]     LAST_BAD
);

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    chk_state_t       state, state_nxt;
    logic [GW-1:0]    good_cnt, good_nxt, good_inc;
    logic [WIDTH-1:0] prev_cnt, exp_cnt;
    logic             prev_en;
    logic             match, wrap_hit;
    logic             err_nxt, wrap_nxt;

    always_comb begin
        exp_cnt   = prev_en ? (prev_cnt + WIDTH'(1)) : prev_cnt;
        match     = (CNT_IN == exp_cnt);
        wrap_hit  = prev_en && (prev_cnt == '1) && (CNT_IN == '0);
        good_inc  = good_cnt + GW'(1);

        state_nxt = state;
        good_nxt  = good_cnt;
        err_nxt   = 1'b0;
        wrap_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_SYNC;
                good_nxt  = '0;
            end
            S_SYNC: begin
                wrap_nxt = wrap_hit;
                if (!match) begin
                    good_nxt = '0;
                end else if (prev_en) begin
                    if (good_inc == GW'(LOCK_COUNT)) begin
                        state_nxt = S_LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_inc;
                    end
                end
            end
            S_LOCKED: begin
                wrap_nxt = wrap_hit;
                if (!match) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_SYNC;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    // History is captured on every non-reset edge, including the IDLE edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= S_IDLE;
            good_cnt <= '0;
            prev_cnt <= '0;
            prev_en  <= 1'b0;
            LOCKED   <= 1'b0;
            ERROR    <= 1'b0;
            WRAP     <= 1'b0;
            LAST_BAD <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            prev_cnt <= CNT_IN;
            prev_en  <= ENABLE;
            LOCKED   <= (state_nxt == S_LOCKED);
            ERROR    <= err_nxt;
            WRAP     <= wrap_nxt;
            if (err_nxt) begin
                LAST_BAD <= CNT_IN;
            end
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk (CLOCK),
        .clr (RESET),
        .inc (err_nxt && !RESET),
        .cnt (ERR_COUNT)
    );

endmodule

// File: tb/tb_binary_counter3_checker.sv
// Directed bench: cycle table with hand-computed outputs, plus a free-running count sequence.
module tb_binary_counter3_checker;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic [2:0] CNT_IN = 3'd0;

    logic       locked8, error8, wrap8;
    logic [7:0] err_count8;
    logic [2:0] last_bad8;
    logic       locked2, error2, wrap2;
    logic [1:0] err_count2;
    logic [2:0] last_bad2;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK = ~CLOCK;

    binary_counter3_checker dut8 (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .CNT_IN    (CNT_IN),
        .LOCKED    (locked8),
        .ERROR     (error8),
        .WRAP      (wrap8),
        .ERR_COUNT (err_count8),
        .LAST_BAD  (last_bad8)
    );

    binary_counter3_checker #(.ERR_CNT_W(2)) dut2 (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .CNT_IN    (CNT_IN),
        .LOCKED    (locked2),
        .ERROR     (error2),
        .WRAP      (wrap2),
        .ERR_COUNT (err_count2),
        .LAST_BAD  (last_bad2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] cnt;
        logic       l;
        logic       e;
        logic       w;
        int         ec;
        logic [2:0] lb;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic en, input int cnt, input logic l,
                     input logic e, input logic w, input int ec, input int lb);
        vec_t t;
        t.rst = rst; t.en = en; t.cnt = 3'(cnt);
        t.l = l; t.e = e; t.w = w; t.ec = ec; t.lb = 3'(lb);
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [2:0] cnt);
        @(negedge CLOCK);
        RESET  = rst;
        ENABLE = en;
        CNT_IN = cnt;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        // rst en cnt | LOCKED ERROR WRAP ERR_COUNT LAST_BAD
        v(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) v(0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0, 0);
        v(0, 1, 2, 1, 0, 0, 0, 0);
        v(0, 1, 3, 1, 0, 0, 0, 0);
        v(0, 1, 4, 1, 0, 0, 0, 0);
        v(0, 1, 5, 1, 0, 0, 0, 0);
        v(0, 1, 6, 1, 0, 0, 0, 0);
        v(0, 1, 7, 1, 0, 0, 0, 0);
        v(0, 1, 0, 1, 0, 1, 0, 0);
        v(0, 1, 1, 1, 0, 0, 0, 0);
        v(0, 1, 2, 1, 0, 0, 0, 0);
        v(0, 1, 3, 1, 0, 0, 0, 0);
        // skip 4: error while locked, then relock on 6,7
        v(0, 1, 5, 0, 1, 0, 1, 5);
        v(0, 1, 6, 0, 0, 0, 1, 5);
        v(0, 1, 7, 1, 0, 0, 1, 5);
        v(0, 1, 0, 1, 0, 1, 1, 5);
        v(0, 1, 1, 1, 0, 0, 1, 5);
        v(0, 1, 2, 1, 0, 0, 1, 5);
        v(0, 1, 3, 1, 0, 0, 1, 5);
        v(0, 1, 4, 1, 0, 0, 1, 5);
        v(0, 0, 5, 1, 0, 0, 1, 5);
        // count moves while disabled
        v(0, 0, 6, 0, 1, 0, 2, 6);
        // one disabled cycle mid-acquisition neither advances nor breaks it
        v(0, 1, 6, 0, 0, 0, 2, 6);
        v(0, 0, 7, 0, 0, 0, 2, 6);
        v(0, 1, 7, 0, 0, 0, 2, 6);
        v(0, 1, 0, 1, 0, 1, 2, 6);
        // reset while locked, then a jump on the IDLE capture edge
        v(1, 1, 1, 0, 0, 0, 0, 0);
        v(0, 1, 5, 0, 0, 0, 0, 0);
        v(0, 1, 6, 0, 0, 0, 0, 0);
        v(0, 1, 7, 1, 0, 0, 0, 0);
        // five errors, relocking between each
        v(0, 1, 1, 0, 1, 0, 1, 1);
        v(0, 1, 2, 0, 0, 0, 1, 1);
        v(0, 1, 3, 1, 0, 0, 1, 1);
        v(0, 1, 5, 0, 1, 0, 2, 5);
        v(0, 1, 6, 0, 0, 0, 2, 5);
        v(0, 1, 7, 1, 0, 0, 2, 5);
        v(0, 1, 1, 0, 1, 0, 3, 1);
        v(0, 1, 2, 0, 0, 0, 3, 1);
        v(0, 1, 3, 1, 0, 0, 3, 1);
        v(0, 1, 5, 0, 1, 0, 4, 5);
        v(0, 1, 6, 0, 0, 0, 4, 5);
        v(0, 1, 7, 1, 0, 0, 4, 5);
        v(0, 1, 1, 0, 1, 0, 5, 1);
        v(0, 1, 2, 0, 0, 0, 5, 1);
        v(0, 1, 3, 1, 0, 0, 5, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].cnt);
            check("locked",     i, int'(locked8),    int'(vecs[i].l));
            check("error",      i, int'(error8),     int'(vecs[i].e));
            check("wrap",       i, int'(wrap8),      int'(vecs[i].w));
            check("err_count",  i, int'(err_count8), vecs[i].ec);
            check("last_bad",   i, int'(last_bad8),  int'(vecs[i].lb));
            check("err_count2", i, int'(err_count2), (vecs[i].ec > 3) ? 3 : vecs[i].ec);
        end

        // Free-running count from 6 with ENABLE high: lock at the third edge, wrap on 7->0.
        step(1'b1, 1'b1, 3'd6);
        check("seq_rst_locked", 100, int'(locked8), 0);
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] c;
            c = 3'((6 + k - 1) % 8);
            step(1'b0, 1'b1, c);
            check("seq_locked", 100 + k, int'(locked8), (k >= 3) ? 1 : 0);
            check("seq_wrap",   100 + k, int'(wrap8), (k >= 2 && c == 3'd0) ? 1 : 0);
            check("seq_error",  100 + k, int'(error8), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
